// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-transaction memory controller port between NUM_PORTS
// requesters. Each requester issues a one-cycle begin_wr/begin_rd strobe and
// holds its address/data until it sees its one-cycle finish pulse.
//
// Features:
//   - per-port pending latch with a recorded op type (write wins if both
//     strobes arrive together),
//   - round-robin grant starting after the last granted port,
//   - sticky per-port collision flag for dropped or ambiguous strobes,
//   - busy-cycle watchdog that aborts a stuck transaction and returns all-ones
//     read data so the requester never hangs.
//
// Ports:
//   mclk, reset_n          clock, asynchronous active-low reset
//   p_begin_wr/p_begin_rd  per-port request strobes
//   p_addr, p_data_wr      packed per-port address / write data
//   p_finish, p_data_rd    per-port completion pulse and read data
//   p_collision            sticky per-port dropped-strobe flag
//   mem_req/mem_wr/mem_addr/mem_data_wr   downstream request (registered)
//   mem_data_rd, mem_ack   downstream response
//   timeout_err            sticky watchdog-abort flag
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                            mclk,
  input  logic                            reset_n,
  input  logic [NUM_PORTS-1:0]            p_begin_wr,
  input  logic [NUM_PORTS-1:0]            p_begin_rd,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] p_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] p_data_wr,
  output logic [NUM_PORTS-1:0]            p_finish,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] p_data_rd,
  output logic [NUM_PORTS-1:0]            p_collision,
  output logic                            mem_req,
  output logic                            mem_wr,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [DATA_WIDTH-1:0]           mem_data_wr,
  input  logic [DATA_WIDTH-1:0]           mem_data_rd,
  input  logic                            mem_ack,
  output logic                            timeout_err
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Reset synchroniser: assertion is immediate, release is aligned to mclk.
  logic [1:0] rst_sync_q;
  logic       rst_n_s;

  // Two-stage release synchroniser for the internal reset.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_q[1];

  // Registered state
  state_t                 state_q,       state_d;
  logic [NUM_PORTS-1:0]   pending_q,     pending_d;
  logic [NUM_PORTS-1:0]   wr_q,          wr_d;
  logic [PW-1:0]          rr_q,          rr_d;
  logic [PW-1:0]          grant_q,       grant_d;
  logic                   mem_req_q,     mem_req_d;
  logic                   mem_wr_q,      mem_wr_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q,    mem_addr_d;
  logic [DATA_WIDTH-1:0]  mem_data_wr_q, mem_data_wr_d;
  logic [NUM_PORTS-1:0]   p_finish_q,    p_finish_d;
  logic [NUM_PORTS-1:0]   p_collision_q, p_collision_d;
  logic                   timeout_err_q, timeout_err_d;
  logic [CW-1:0]          wd_cnt_q,      wd_cnt_d;
  logic [DATA_WIDTH-1:0]  rd_data_q [NUM_PORTS];
  logic [DATA_WIDTH-1:0]  rd_data_d [NUM_PORTS];

  // Strobe classification
  logic [NUM_PORTS-1:0]   strobe_s;
  logic [NUM_PORTS-1:0]   accept_s;
  logic [NUM_PORTS-1:0]   drop_s;
  logic [NUM_PORTS-1:0]   both_s;
  logic [NUM_PORTS-1:0]   req_s;
  logic [NUM_PORTS-1:0]   op_wr_s;
  logic                   grant_found_s;
  logic [PW-1:0]          grant_pick_s;
  logic                   wd_expired_s;

  // pending_q stays set from acceptance until completion, so it also covers
  // the port in service. It is cleared on the ack edge, which is why a strobe
  // coinciding with p_finish is naturally accepted.
  assign strobe_s = p_begin_wr | p_begin_rd;
  assign accept_s = strobe_s & ~pending_q;
  assign drop_s   = strobe_s & pending_q;
  assign both_s   = p_begin_wr & p_begin_rd;

  // Newly accepted strobes take part in arbitration in the same cycle, giving
  // one-cycle strobe-to-mem_req latency.
  assign req_s    = pending_q | accept_s;
  assign op_wr_s  = (pending_q & wr_q) | (~pending_q & p_begin_wr);
  assign wr_d     = (accept_s & p_begin_wr) | (~accept_s & wr_q);

  assign wd_expired_s = (TIMEOUT != 0) && (wd_cnt_q == CW'(TIMEOUT - 1));

  // Round-robin search: first requesting port after rr_q, wrapping modulo NUM_PORTS.
  always_comb begin
    int idx;
    grant_found_s = 1'b0;
    grant_pick_s  = {PW{1'b0}};
    idx           = 0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = (int'(rr_q) + k) % NUM_PORTS;
      if (!grant_found_s && req_s[idx]) begin
        grant_found_s = 1'b1;
        grant_pick_s  = PW'(idx);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Next-state logic for the grant FSM, latches, watchdog and outputs.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q | accept_s;
    rr_d          = rr_q;
    grant_d       = grant_q;
    mem_req_d     = mem_req_q;
    mem_wr_d      = mem_wr_q;
    mem_addr_d    = mem_addr_q;
    mem_data_wr_d = mem_data_wr_q;
    p_finish_d    = {NUM_PORTS{1'b0}};
    p_collision_d = p_collision_q | drop_s | both_s;
    timeout_err_d = timeout_err_q;
    wd_cnt_d      = wd_cnt_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      rd_data_d[i] = rd_data_q[i];
    end

    case (state_q)
      ST_IDLE: begin
        if (grant_found_s) begin
          grant_d       = grant_pick_s;
          rr_d          = grant_pick_s;
          mem_req_d     = 1'b1;
          mem_wr_d      = op_wr_s[grant_pick_s];
          mem_addr_d    = p_addr[grant_pick_s*ADDR_WIDTH +: ADDR_WIDTH];
          mem_data_wr_d = p_data_wr[grant_pick_s*DATA_WIDTH +: DATA_WIDTH];
          wd_cnt_d      = {CW{1'b0}};
          state_d       = ST_BUSY;
        end else begin
          mem_req_d     = 1'b0;
        end
      end

      ST_BUSY: begin
        if (mem_ack) begin
          if (!mem_wr_q) begin
            rd_data_d[grant_q] = mem_data_rd;
          end else begin
            rd_data_d[grant_q] = rd_data_q[grant_q];
          end
          p_finish_d[grant_q] = 1'b1;
          pending_d[grant_q]  = 1'b0;
          mem_req_d           = 1'b0;
          state_d             = ST_IDLE;
        end else if (wd_expired_s) begin
          // Abort: the requester still gets a finish, with all-ones data.
          rd_data_d[grant_q]  = {DATA_WIDTH{1'b1}};
          p_finish_d[grant_q] = 1'b1;
          pending_d[grant_q]  = 1'b0;
          mem_req_d           = 1'b0;
          timeout_err_d       = 1'b1;
          state_d             = ST_IDLE;
        end else begin
          wd_cnt_d            = wd_cnt_q + CW'(1);
        end
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge mclk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q       <= ST_IDLE;
      pending_q     <= {NUM_PORTS{1'b0}};
      wr_q          <= {NUM_PORTS{1'b0}};
      rr_q          <= PW'(NUM_PORTS - 1);
      grant_q       <= {PW{1'b0}};
      mem_req_q     <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_addr_q    <= {ADDR_WIDTH{1'b0}};
      mem_data_wr_q <= {DATA_WIDTH{1'b0}};
      p_finish_q    <= {NUM_PORTS{1'b0}};
      p_collision_q <= {NUM_PORTS{1'b0}};
      timeout_err_q <= 1'b0;
      wd_cnt_q      <= {CW{1'b0}};
      for (int i = 0; i < NUM_PORTS; i++) begin
        rd_data_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      wr_q          <= wr_d;
      rr_q          <= rr_d;
      grant_q       <= grant_d;
      mem_req_q     <= mem_req_d;
      mem_wr_q      <= mem_wr_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_wr_q <= mem_data_wr_d;
      p_finish_q    <= p_finish_d;
      p_collision_q <= p_collision_d;
      timeout_err_q <= timeout_err_d;
      wd_cnt_q      <= wd_cnt_d;
      for (int i = 0; i < NUM_PORTS; i++) begin
        rd_data_q[i] <= rd_data_d[i];
      end
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_wr      = mem_wr_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data_wr = mem_data_wr_q;
  assign p_finish    = p_finish_q;
  assign p_collision = p_collision_q;
  assign timeout_err = timeout_err_q;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_rd
    assign p_data_rd[g*DATA_WIDTH +: DATA_WIDTH] = rd_data_q[g];
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// Self-checking bench for mem_port_arbiter (3 ports, watchdog of 8 cycles).
// A transaction-level reference model is stepped on every rising edge from the
// same inputs the DUT sees; a negedge process compares all outputs against it.
// Directed scenarios add hand-computed literal expectations, followed by a
// randomized phase.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int N  = 3;
  localparam int AW = 20;
  localparam int DW = 8;
  localparam int TO = 8;

  logic              mclk    = 1'b0;
  logic              reset_n = 1'b1;
  logic [N-1:0]      bw      = '0;
  logic [N-1:0]      br      = '0;
  logic [N*AW-1:0]   p_addr;
  logic [N*DW-1:0]   p_data_wr;
  logic [N-1:0]      p_finish;
  logic [N*DW-1:0]   p_data_rd;
  logic [N-1:0]      p_collision;
  logic              mem_req;
  logic              mem_wr;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_data_wr;
  logic [DW-1:0]     mem_data_rd = '0;
  logic              mem_ack     = 1'b0;
  logic              timeout_err;

  logic [AW-1:0]     addr_a [N];
  logic [DW-1:0]     wdat_a [N];

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign p_addr[g*AW +: AW]    = addr_a[g];
    assign p_data_wr[g*DW +: DW] = wdat_a[g];
  end

  mem_port_arbiter #(
    .NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .mclk(mclk), .reset_n(reset_n),
    .p_begin_wr(bw), .p_begin_rd(br),
    .p_addr(p_addr), .p_data_wr(p_data_wr),
    .p_finish(p_finish), .p_data_rd(p_data_rd), .p_collision(p_collision),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_data_wr(mem_data_wr), .mem_data_rd(mem_data_rd),
    .mem_ack(mem_ack), .timeout_err(timeout_err)
  );

  always #5 mclk = ~mclk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit           m_pend [N];
  bit           m_opwr [N];
  bit           m_busy;
  int           m_port;
  int           m_cnt;
  int           m_last;
  logic         e_req, e_wr, e_terr;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic [N-1:0]  e_fin, e_coll;
  logic [DW-1:0] e_rd [N];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 1'b0; m_opwr[i] = 1'b0; e_rd[i] = '0;
    end
    m_busy = 1'b0; m_port = 0; m_cnt = 0; m_last = N - 1;
    e_req = 1'b0; e_wr = 1'b0; e_addr = '0; e_wdata = '0;
    e_fin = '0; e_coll = '0; e_terr = 1'b0;
  endtask

  task automatic model_complete();
    e_fin[m_port]  = 1'b1;
    m_pend[m_port] = 1'b0;
    m_busy         = 1'b0;
    e_req          = 1'b0;
  endtask

  // One clock edge worth of behaviour, using the inputs present at that edge.
  task automatic model_step();
    bit was_busy;
    bit old_pend [N];
    int p;
    was_busy = m_busy;
    old_pend = m_pend;
    e_fin    = '0;
    if (was_busy) begin
      if (mem_ack) begin
        if (!e_wr) e_rd[m_port] = mem_data_rd;
        model_complete();
      end else begin
        m_cnt++;
        if (m_cnt == TO) begin
          e_rd[m_port] = '1;
          e_terr       = 1'b1;
          model_complete();
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (bw[i] || br[i]) begin
        if (old_pend[i] || (bw[i] && br[i])) e_coll[i] = 1'b1;
        if (!old_pend[i]) begin
          m_pend[i] = 1'b1;
          m_opwr[i] = bw[i];
        end
      end
    end
    if (!was_busy) begin
      for (int k = 1; k <= N; k++) begin
        p = (m_last + k) % N;
        if (!m_busy && m_pend[p]) begin
          m_busy  = 1'b1;
          m_port  = p;
          m_last  = p;
          m_cnt   = 0;
          e_req   = 1'b1;
          e_wr    = m_opwr[p];
          e_addr  = addr_a[p];
          e_wdata = wdat_a[p];
        end
      end
    end
  endtask

  // Compare all outputs against the model away from the active edge.
  always @(negedge mclk) begin
    if (cmp_en) begin
      chk("mem_req", mem_req, e_req);
      if (e_req) begin
        chk("mem_wr", mem_wr, e_wr);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_data_wr", mem_data_wr, e_wdata);
      end
      chk("p_finish", p_finish, e_fin);
      chk("p_collision", p_collision, e_coll);
      chk("timeout_err", timeout_err, e_terr);
      for (int i = 0; i < N; i++) begin
        chk($sformatf("p_data_rd%0d", i), p_data_rd[i*DW +: DW], e_rd[i]);
      end
    end
  end

  // Advance one clock: model follows the edge, strobes/ack are one-cycle pulses.
  task automatic tick();
    @(posedge mclk);
    if (!reset_n) model_reset();
    else model_step();
    #1;
    bw = '0; br = '0; mem_ack = 1'b0;
  endtask

  task automatic reset_pulse();
    reset_n = 1'b0;
    model_reset();
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick(); tick();
  endtask

  // Wait (bounded) for a request, identify the port by address, then ack it.
  task automatic serve(input logic [DW-1:0] d, output int port);
    int n;
    n = 0;
    port = -1;
    while (mem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("serve_req", mem_req, 1'b1);
    for (int i = 0; i < N; i++) begin
      if (mem_addr == addr_a[i]) port = i;
    end
    mem_ack = 1'b1;
    mem_data_rd = d;
    tick();
  endtask

  initial begin
    int pt;
    int n;
    int fin_cnt;
    int r;
    addr_a[0] = 20'h00123; addr_a[1] = 20'h00456; addr_a[2] = 20'h00789;
    for (int i = 0; i < N; i++) wdat_a[i] = 8'h00;
    #1;
    reset_n = 1'b0;
    model_reset();
    cmp_en = 1'b1;
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick(); tick();

    // Reset state
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_p_finish", p_finish, 3'b000);
    chk("rst_p_collision", p_collision, 3'b000);
    chk("rst_timeout_err", timeout_err, 1'b0);
    chk("rst_p_data_rd", p_data_rd, 24'h000000);

    // Single read from port 0
    br = 3'b001;
    tick();
    chk("rd_mem_req", mem_req, 1'b1);
    chk("rd_mem_wr", mem_wr, 1'b0);
    chk("rd_mem_addr", mem_addr, 20'h00123);
    tick(); tick();
    mem_ack = 1'b1; mem_data_rd = 8'hA5;
    tick();
    chk("rd_finish", p_finish, 3'b001);
    chk("rd_data", p_data_rd[7:0], 8'hA5);
    chk("rd_req_drop", mem_req, 1'b0);
    tick();
    chk("rd_finish_once", p_finish, 3'b000);

    // Round robin from a fresh reset
    reset_pulse();
    addr_a[0] = 20'h00A00; addr_a[1] = 20'h00B11; addr_a[2] = 20'h00C22;
    br = 3'b111;
    tick();
    serve(8'h10, pt); chk("rr_first", pt, 0);
    serve(8'h20, pt); chk("rr_second", pt, 1);
    serve(8'h30, pt); chk("rr_third", pt, 2);
    br = 3'b101;
    tick();
    serve(8'h40, pt); chk("rr_again_first", pt, 0);
    serve(8'h50, pt); chk("rr_again_second", pt, 2);

    // Write from port 1 leaves its read data untouched
    addr_a[1] = 20'h0FFFF; wdat_a[1] = 8'h3C;
    bw = 3'b010;
    tick();
    chk("wr_mem_wr", mem_wr, 1'b1);
    chk("wr_mem_data", mem_data_wr, 8'h3C);
    chk("wr_mem_addr", mem_addr, 20'h0FFFF);
    mem_ack = 1'b1; mem_data_rd = 8'hEE;
    tick();
    chk("wr_finish", p_finish, 3'b010);
    chk("wr_rd_unchanged", p_data_rd[15:8], 8'h20);

    // Collision: second strobe on port 0 while it is in service
    br = 3'b001;
    tick();
    tick();
    br = 3'b001;
    tick();
    tick();
    mem_ack = 1'b1; mem_data_rd = 8'h5A;
    tick();
    chk("col_finish", p_finish, 3'b001);
    fin_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (mem_req === 1'b1 || p_finish !== 3'b000) fin_cnt++;
    end
    chk("col_no_second_txn", fin_cnt, 0);
    chk("col_flags", p_collision, 3'b001);

    // Watchdog abort on port 2, then port 1 served normally
    addr_a[2] = 20'h00D33;
    br = 3'b100;
    tick();
    n = 0;
    while (mem_req === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    chk("to_req_cycles", n, 8);
    chk("to_finish", p_finish, 3'b100);
    chk("to_data", p_data_rd[23:16], 8'hFF);
    chk("to_err", timeout_err, 1'b1);
    addr_a[1] = 20'h00E44;
    br = 3'b010;
    tick();
    serve(8'h77, pt);
    chk("to_next_port", pt, 1);
    chk("to_next_finish", p_finish, 3'b010);
    chk("to_next_data", p_data_rd[15:8], 8'h77);
    chk("to_err_sticky", timeout_err, 1'b1);

    // Asynchronous reset while busy
    br = 3'b001;
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("ar_req_drop", mem_req, 1'b0);
    tick();
    chk("ar_no_finish", p_finish, 3'b000);
    tick();
    reset_n = 1'b1;
    tick(); tick(); tick();
    addr_a[0] = 20'h00A00; addr_a[1] = 20'h00B11; addr_a[2] = 20'h00C22;
    br = 3'b110;
    tick();
    chk("ar_next_grant", mem_addr, 20'h00B11);
    serve(8'h01, pt);
    serve(8'h02, pt);
    br = 3'b111;
    tick();
    chk("ar_port0_first_after_rr", mem_addr, 20'h00A00);
    serve(8'h03, pt);
    serve(8'h04, pt);
    serve(8'h05, pt);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        r = $urandom_range(0, 99);
        if (r < 22) begin
          if (r < 12) br[i] = 1'b1;
          else if (r < 20) bw[i] = 1'b1;
          else begin br[i] = 1'b1; bw[i] = 1'b1; end
          if (!m_pend[i]) begin
            addr_a[i] = AW'($urandom);
            wdat_a[i] = DW'($urandom);
          end
        end
      end
      mem_ack     = ($urandom_range(0, 99) < 40);
      mem_data_rd = DW'($urandom);
      tick();
    end
    tick(); tick();
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Parametrised N-port memory request arbiter. It generalises the fixed two-port (SPI + serial) memory sharing in the SPI EEPROM emulator to NUM_PORTS requesters. It keeps the begin_wr/begin_rd/finish handshake per port and adds round-robin fairness, per-port pending latches, collision flags and a busy-cycle watchdog. It sits between the requesters (SPI emulator, serial loader, future ports) and one downstream single-transaction memory controller port.

Parameters:
NUM_PORTS, 2, number of requester ports (2..8)
ADDR_WIDTH, 20, byte address width
DATA_WIDTH, 8, data width
TIMEOUT, 255, max mclk cycles to wait for mem_ack before abort; 0 disables the watchdog

Ports:
mclk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
p_begin_wr  in  NUM_PORTS  per-port one-cycle write strobe
p_begin_rd  in  NUM_PORTS  per-port one-cycle read strobe
p_addr  in  NUM_PORTS*ADDR_WIDTH  port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]; held stable from strobe until finish
p_data_wr  in  NUM_PORTS*DATA_WIDTH  write data, same packing and hold rule
p_finish  out  NUM_PORTS  one-cycle completion pulse per port
p_data_rd  out  NUM_PORTS*DATA_WIDTH  read data per port; valid with p_finish, held until that port's next finish
p_collision  out  NUM_PORTS  sticky flag: strobe dropped on this port
mem_req  out  1  downstream request, held until ack or abort
mem_wr  out  1  1 = write, 0 = read; stable while mem_req
mem_addr  out  ADDR_WIDTH  downstream address
mem_data_wr  out  DATA_WIDTH  downstream write data
mem_data_rd  in  DATA_WIDTH  read data, sampled on the mem_ack cycle
mem_ack  in  1  one-cycle completion from downstream; ignored while mem_req = 0
timeout_err  out  1  sticky: a transaction was aborted by the watchdog

Behaviour:
- Reset (async assert, sync release): all outputs 0, pending = 0, wr flags = 0, rr pointer = NUM_PORTS-1 (port 0 has first priority), state IDLE, watchdog count = 0.
- Per-port pending latch: set on p_begin_wr or p_begin_rd; records the op type. Write wins if both strobes hit together, and that port's p_collision is also set.
- A strobe while the port is already pending or in service is dropped and sets p_collision for that port. Exception: a strobe in the same cycle the port's p_finish is high is accepted as a new request.
- States:
  - IDLE: if any port is pending, grant the first pending port searching from rr+1 upward with wrap-around. Register mem_addr, mem_data_wr and mem_wr from that port's latched inputs, assert mem_req, set rr = grant, go to BUSY.
  - BUSY: hold all mem_* outputs stable. On mem_ack: capture mem_data_rd into that port's p_data_rd (reads only; writes leave p_data_rd unchanged), pulse p_finish[grant] on the next cycle, clear pending, drop mem_req, go to IDLE.
- Timing: mem_req is low for at least one cycle between transactions. Minimum latency is 1 cycle from strobe to mem_req, and 1 cycle from mem_ack to p_finish.
- mem_ack may arrive in the first cycle mem_req is high.
- Watchdog: counts BUSY cycles. When the count reaches TIMEOUT without mem_ack, drop mem_req, set timeout_err, and pulse p_finish for the granted port with p_data_rd set to all ones. The port must not hang.
- p_collision and timeout_err clear only on reset.
- Reset mid-transaction: mem_req drops immediately (async), pending requests are lost, and no p_finish is issued.
- Port index arithmetic wraps modulo NUM_PORTS; NUM_PORTS need not be a power of two.

Test Plan:
- Single read: NUM_PORTS=2, strobe p_begin_rd[0] with addr 0x00123; downstream acks after 3 cycles with 0xA5 -> mem_req high 1 cycle after strobe, mem_wr=0, mem_addr=0x00123; p_finish[0] pulses 1 cycle after ack; p_data_rd[0]=0xA5.
- Round-robin: NUM_PORTS=3, all three ports strobe reads in the same cycle; downstream acks each after 1 cycle -> grant order 0,1,2. Then re-strobe ports 2 and 0 together -> port 0 is granted first (rr=2), then port 2.
- Write path: port 1 writes 0x3C to 0x0FFFF -> mem_wr=1, mem_data_wr=0x3C; p_finish[1] pulses; p_data_rd[1] is unchanged from its previous value.
- Collision: strobe port 0 twice, 2 cycles apart, while its first request is BUSY -> exactly one mem_req and one p_finish; p_collision[0]=1, other p_collision bits stay 0.
- Timeout: TIMEOUT=8, never assert mem_ack -> mem_req drops after 8 BUSY cycles; timeout_err=1; p_finish pulses with p_data_rd=0xFF; a following request from another port is served normally.
- Async reset: assert reset_n low while BUSY -> mem_req=0 immediately, no p_finish issued; after release the next grant goes to port 0.
